// File: rtl/button_irq_slave_if.sv
// Avalon-MM slave bus bundle plus the level interrupt returned to the master.
// Read, write, address, data and byte enables flow master to slave; readdata, waitrequest and irq flow back.
interface button_irq_slave_if;
    logic [1:0]  avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic [31:0] avl_readdata;
    logic        avl_waitrequest;
    logic        irq;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        input  avl_readdata, avl_waitrequest, irq
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        output avl_readdata, avl_waitrequest, irq
    );
endinterface

// File: rtl/button_irq_slave.sv
// Button input block: 2-flop sync, per-bit debounce, sticky edge latch, masked level irq; writes single-cycle.
// Reads take one wait cycle (waitrequest high in the request cycle, data in the next); a read paired with a write is dropped.
module button_irq_slave #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_irq_slave_if.slave    bus,
    input  logic [WIDTH-1:0]     pins_in
);
    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d, edge_q, edge_d, mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [1:0]       ctrl_q, ctrl_d;
    logic             irq_q, irq_d;
    state_t           state_q, state_d;
    logic [31:0]      cap_q, cap_d;

    logic [31:0]      lane_mask;
    logic [31:0]      wr_word;
    logic [WIDTH-1:0] wr_bits, rise, fall, set_bits;
    logic             wr_edge, wr_mask, wr_ctrl;
    logic [31:0]      rd_val;

    always_comb begin
        lane_mask = {{8{bus.avl_byteenable[3]}}, {8{bus.avl_byteenable[2]}},
                     {8{bus.avl_byteenable[1]}}, {8{bus.avl_byteenable[0]}}};
        wr_word   = bus.avl_writedata & lane_mask;
        wr_bits   = wr_word[WIDTH-1:0];
        wr_edge   = bus.avl_write && (bus.avl_address == 2'd1);
        wr_mask   = bus.avl_write && (bus.avl_address == 2'd2);
        wr_ctrl   = bus.avl_write && (bus.avl_address == 2'd3) && bus.avl_byteenable[0];
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        sync1_d  = pins_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Set beats a same-cycle W1C; irq follows the registered EDGE/MASK one edge later.
    always_comb begin
        rise     = stable_d & ~stable_q;
        fall     = ~stable_d & stable_q;
        set_bits = (rise & {WIDTH{ctrl_q[0]}}) | (fall & {WIDTH{ctrl_q[1]}});
        edge_d   = (edge_q & ~(wr_edge ? wr_bits : '0)) | set_bits;
        mask_d   = wr_mask ? ((mask_q & ~lane_mask[WIDTH-1:0]) | wr_bits) : mask_q;
        ctrl_d   = wr_ctrl ? bus.avl_writedata[1:0] : ctrl_q;
        irq_d    = |(edge_q & mask_q);
    end

    always_comb begin
        rd_val = '0;
        case (bus.avl_address)
            2'd0:    rd_val = 32'(stable_q);
            2'd1:    rd_val = 32'(edge_q);
            2'd2:    rd_val = 32'(mask_q);
            default: rd_val = {30'd0, ctrl_q};
        endcase
    end

    // waitrequest is gated by rst_n so a stalled master is released the moment reset asserts.
    always_comb begin
        state_d             = state_q;
        cap_d               = cap_q;
        bus.avl_waitrequest = 1'b0;
        bus.avl_readdata    = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.avl_read && !bus.avl_write) begin
                    bus.avl_waitrequest = rst_n;
                    cap_d               = rd_val;
                    state_d             = S_RESP;
                end
            end
            default: begin
                bus.avl_readdata = cap_q;
                state_d          = S_IDLE;
            end
        endcase
    end

    assign bus.irq = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            ctrl_q   <= 2'b01;
            irq_q    <= 1'b0;
            state_q  <= S_IDLE;
            cap_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            ctrl_q   <= ctrl_d;
            irq_q    <= irq_d;
            state_q  <= state_d;
            cap_q    <= cap_d;
        end
    end
endmodule

// File: tb/tb_button_irq_slave.sv
// Directed bench for button_irq_slave: expected read data is queued when a read is issued and checked on response.
module tb_button_irq_slave;
    localparam int W  = 8;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pins_in;

    button_irq_slave_if bus ();

    button_irq_slave #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB),
        .RESET_LEVEL     (8'hFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .pins_in (pins_in)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each call ends 1 time unit after the n-th following rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.avl_address    = a;
        bus.avl_writedata  = d;
        bus.avl_byteenable = be;
        bus.avl_write      = 1'b1;
        tick(1);
        bus.avl_write      = 1'b0;
        bus.avl_byteenable = 4'h0;
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic        done;
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.avl_address = a;
        bus.avl_read    = 1'b1;
        #1;
        check({tag, "_wait"}, {31'd0, bus.avl_waitrequest}, 32'd1);
        done = 1'b0;
        for (int k = 0; k < 4 && !done; k++) begin
            @(posedge clk);
            #1;
            if (!bus.avl_waitrequest) done = 1'b1;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, bus.avl_readdata, e);
        tick(1);
        bus.avl_read = 1'b0;
    endtask

    initial begin
        pins_in            = 8'hFF;
        bus.avl_address    = 2'd0;
        bus.avl_read       = 1'b0;
        bus.avl_write      = 1'b0;
        bus.avl_writedata  = '0;
        bus.avl_byteenable = 4'h0;

        // Reset state
        tick(2);
        check("rst_waitreq", {31'd0, bus.avl_waitrequest}, 32'd0);
        check("rst_readdata", bus.avl_readdata, 32'd0);
        check("rst_irq", {31'd0, bus.irq}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        do_read(2'd0, 32'h0000_00FF, "rst_data");
        do_read(2'd1, 32'h0, "rst_edge");
        do_read(2'd2, 32'h0, "rst_mask");
        do_read(2'd3, 32'h1, "rst_ctrl");
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("rst_irq_quiet", {31'd0, bus.irq}, 32'd0);
        end

        // Falling-edge capture on bit 0
        do_write(2'd3, 32'h2, 4'b0001);
        do_write(2'd2, 32'h1, 4'b1111);
        pins_in[0] = 1'b0;             // sampled at edge 0
        tick(4);                       // after edge 3
        do_read(2'd0, 32'h0000_00FF, "fall_data_early");   // now after edge 5
        check("fall_irq_e5", {31'd0, bus.irq}, 32'd0);
        tick(1);
        check("fall_irq_e6", {31'd0, bus.irq}, 32'd1);
        do_read(2'd0, 32'h0000_00FE, "fall_data");
        do_read(2'd1, 32'h0000_0001, "fall_edge");
        do_write(2'd1, 32'h1, 4'b0001);
        check("clr_irq_hold", {31'd0, bus.irq}, 32'd1);
        tick(1);
        check("clr_irq_low", {31'd0, bus.irq}, 32'd0);
        do_read(2'd1, 32'h0, "clr_edge");

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
        pins_in[3] = 1'b0;
        tick(3);
        pins_in[3] = 1'b1;
        tick(6);
        do_read(2'd0, 32'h0000_00FE, "glitch3_data");
        do_read(2'd1, 32'h0, "glitch3_edge");
        pins_in[3] = 1'b0;
        tick(4);
        pins_in[3] = 1'b1;
        tick(2);                       // after edge 5
        do_read(2'd0, 32'h0000_00F6, "pulse4_data");
        do_read(2'd1, 32'h0000_0008, "pulse4_edge");
        do_read(2'd0, 32'h0000_00FE, "pulse4_back");
        check("pulse4_irq_masked", {31'd0, bus.irq}, 32'd0);
        do_write(2'd1, 32'h8, 4'b0001);

        // Masking and byteenable
        do_write(2'd2, 32'h0, 4'b1111);
        pins_in[5] = 1'b0;
        tick(8);
        check("mask_irq_off", {31'd0, bus.irq}, 32'd0);
        do_read(2'd1, 32'h0000_0020, "mask_edge5");
        do_write(2'd2, 32'hFFFF_FF20, 4'b0001);
        check("mask_irq_same_edge", {31'd0, bus.irq}, 32'd0);
        tick(1);
        check("mask_irq_next_edge", {31'd0, bus.irq}, 32'd1);
        do_read(2'd2, 32'h0000_0020, "mask_be");

        // Set/clear collision on bit 2
        do_write(2'd3, 32'h3, 4'b0001);
        do_write(2'd2, 32'h24, 4'b0001);
        do_write(2'd1, 32'h20, 4'b0001);
        pins_in[2] = 1'b0;
        tick(8);
        do_read(2'd1, 32'h0000_0004, "coll_pre_edge");
        check("coll_pre_irq", {31'd0, bus.irq}, 32'd1);
        pins_in[2] = 1'b1;             // sampled at edge 0
        tick(5);                       // after edge 4
        do_write(2'd1, 32'h4, 4'b0001);  // W1C lands on edge 5 with the rising flip
        check("coll_irq_e5", {31'd0, bus.irq}, 32'd1);
        tick(1);
        check("coll_irq_e6", {31'd0, bus.irq}, 32'd1);
        do_read(2'd1, 32'h0000_0004, "coll_edge");
        do_write(2'd1, 32'h4, 4'b0001);
        tick(1);
        check("coll_clr_irq", {31'd0, bus.irq}, 32'd0);
        do_read(2'd1, 32'h0, "coll_clr_edge");

        // Read and write together: write wins, read dropped
        bus.avl_address    = 2'd2;
        bus.avl_writedata  = 32'h3;
        bus.avl_byteenable = 4'b1111;
        bus.avl_read       = 1'b1;
        bus.avl_write      = 1'b1;
        #1;
        check("rw_waitreq", {31'd0, bus.avl_waitrequest}, 32'd0);
        tick(1);
        bus.avl_read  = 1'b0;
        bus.avl_write = 1'b0;
        check("rw_readdata", bus.avl_readdata, 32'd0);
        do_read(2'd2, 32'h0000_0003, "rw_mask");

        // Read handshake and reset during the wait cycle
        do_write(2'd3, 32'h1, 4'b0001);
        do_read(2'd3, 32'h0000_0001, "hs_ctrl");
        bus.avl_address = 2'd3;
        bus.avl_read    = 1'b1;
        #1;
        check("hs_mid_waitreq", {31'd0, bus.avl_waitrequest}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("hs_rst_waitreq", {31'd0, bus.avl_waitrequest}, 32'd0);
        check("hs_rst_readdata", bus.avl_readdata, 32'd0);
        tick(1);
        bus.avl_read = 1'b0;
        rst_n = 1'b1;
        tick(1);
        do_read(2'd3, 32'h0000_0001, "hs_after_rst_ctrl");
        do_read(2'd2, 32'h0, "hs_after_rst_mask");
        tick(10);
        do_read(2'd0, 32'h0000_00DE, "hs_after_rst_data");
        do_read(2'd1, 32'h0, "hs_after_rst_edge");

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
